// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings and widths for the shift sequencer that drives the left barrel shifter.
package shift_seq_ctrl_pkg;

    localparam int N = 16;
    localparam int C = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS1 = 2'b01,
        PASS2 = 2'b10,
        DONE  = 2'b11
    } state_e;

    function automatic logic is_rotate(input op_e op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_bit_rev.sv
// Pure wiring: output bit i is input bit N-1-i.
module bit_rev #(
    parameter int N = 16
) (
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    for (genvar i = 0; i < N; i++) begin : g_rev
        assign q[i] = d[N-1-i];
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that builds SLL/SRL/ROL/ROR out of one external left shifter,
// using bit reversal and one or two passes; result held on a valid/ready port.
module shift_seq_ctrl #(
    parameter int N = shift_seq_ctrl_pkg::N,
    parameter int C = shift_seq_ctrl_pkg::C
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] req_data,
    input  logic [C-1:0] req_cnt,
    output logic [N-1:0] sh_in,
    output logic [C-1:0] sh_cnt,
    input  logic [N-1:0] sh_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data
);
    import shift_seq_ctrl_pkg::*;

    typedef struct packed {
        op_e          op;
        logic [N-1:0] a;
        logic [C-1:0] k;
    } req_t;

    state_e       state;
    req_t         req_q;
    logic [N-1:0] acc;

    op_e          in_op;
    logic [N-1:0] rev_a_src;
    logic [N-1:0] rev_a;
    logic [N-1:0] rev_sh;
    logic [C-1:0] k_neg_in;
    logic [C-1:0] k_neg_q;
    logic [N-1:0] pass1_acc;
    logic [N-1:0] pass2_acc;

    assign in_op = op_e'(req_op);

    // One reverser serves the accept edge (live operand) and PASS2 (latched operand).
    assign rev_a_src = (state == IDLE) ? req_data : req_q.a;

    bit_rev #(.N(N)) u_rev_a  (.d(rev_a_src), .q(rev_a));
    bit_rev #(.N(N)) u_rev_sh (.d(sh_out),    .q(rev_sh));

    // Right rotate by k equals left rotate by -k mod N; carry is dropped.
    assign k_neg_in  = C'(0) - req_cnt;
    assign k_neg_q   = C'(0) - req_q.k;

    assign pass1_acc = (req_q.op == OP_SRL) ? rev_sh : sh_out;
    assign pass2_acc = acc | rev_sh;

    // sh_in/sh_cnt are registered: each transition loads the values the next state drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= '0;
            acc       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            sh_in     <= '0;
            sh_cnt    <= '0;
            req_ready <= 1'b1;
        end else if (flush) begin
            state     <= IDLE;
            acc       <= '0;
            res_valid <= 1'b0;
            sh_in     <= '0;
            sh_cnt    <= '0;
            req_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q     <= '{op: in_op, a: req_data, k: req_cnt};
                        state     <= PASS1;
                        req_ready <= 1'b0;
                        case (in_op)
                            OP_SRL: begin
                                sh_in  <= rev_a;
                                sh_cnt <= req_cnt;
                            end
                            OP_ROR: begin
                                sh_in  <= req_data;
                                sh_cnt <= k_neg_in;
                            end
                            default: begin
                                sh_in  <= req_data;
                                sh_cnt <= req_cnt;
                            end
                        endcase
                    end
                end
                PASS1: begin
                    acc <= pass1_acc;
                    if (is_rotate(req_q.op) && (req_q.k != '0)) begin
                        state  <= PASS2;
                        sh_in  <= rev_a;
                        sh_cnt <= (req_q.op == OP_ROL) ? k_neg_q : req_q.k;
                    end else begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= pass1_acc;
                        sh_in     <= '0;
                        sh_cnt    <= '0;
                    end
                end
                PASS2: begin
                    acc       <= pass2_acc;
                    res_data  <= pass2_acc;
                    res_valid <= 1'b1;
                    state     <= DONE;
                    sh_in     <= '0;
                    sh_cnt    <= '0;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed plus randomized checks of shift_seq_ctrl against a plain-arithmetic shift/rotate model.
module tb_shift_seq_ctrl;

    localparam int N = 16;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [N-1:0] req_data = '0;
    logic [C-1:0] req_cnt = '0;
    logic [N-1:0] sh_in;
    logic [C-1:0] sh_cnt;
    logic [N-1:0] sh_out;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Downstream logical left shifter (l_shift_log behaviour): Out = In << Cnt.
    assign sh_out = sh_in << sh_cnt;

    shift_seq_ctrl #(.N(N), .C(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_cnt   (req_cnt),
        .sh_in     (sh_in),
        .sh_cnt    (sh_cnt),
        .sh_out    (sh_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] a);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = a[15-i];
        return r;
    endfunction

    // 0=ROL 1=SLL 2=ROR 3=SRL
    function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input int k);
        logic [15:0] r;
        case (op)
            2'd0:    r = (a << k) | (a >> (16 - k));
            2'd1:    r = a << k;
            2'd2:    r = (a >> k) | (a << (16 - k));
            default: r = a >> k;
        endcase
        return r;
    endfunction

    // Called at a negedge with the block idle; returns at the first negedge after the accept edge.
    task automatic start_req(input string tag, input logic [1:0] op, input logic [15:0] a, input int k);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = a;
        req_cnt   = 4'(k);
        chk({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_data  = 16'($urandom);
        req_cnt   = 4'($urandom);
        chk({tag, "/pass1_sh_in"}, 32'(sh_in), 32'((op == 2'd3) ? rev16(a) : a));
        chk({tag, "/pass1_sh_cnt"}, 32'(sh_cnt), 32'((op == 2'd2) ? ((16 - k) % 16) : k));
    endtask

    task automatic finish_req(input string tag, input logic [1:0] op, input logic [15:0] a,
                              input int k, input int hold);
        int          lat;
        logic [15:0] exp;
        exp = model(op, a, k);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), ((op == 2'd0 || op == 2'd2) && k != 0) ? 32'd2 : 32'd1);
        chk({tag, "/res_data"}, 32'(res_data), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(res_valid), 32'd1);
            chk({tag, "/hold_data"}, 32'(res_data), 32'(exp));
            chk({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "/consumed_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "/consumed_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_req(input string tag, input logic [1:0] op, input logic [15:0] a,
                           input int k, input int hold);
        start_req(tag, op, a, k);
        finish_req(tag, op, a, k, hold);
    endtask

    initial begin
        logic [1:0]  op;
        logic [15:0] a;
        int          k;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst/req_ready", 32'(req_ready), 32'd1);
        chk("rst/res_valid", 32'(res_valid), 32'd0);
        chk("rst/res_data", 32'(res_data), 32'd0);
        chk("rst/sh_in", 32'(sh_in), 32'd0);
        chk("rst/sh_cnt", 32'(sh_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        run_req("sll_8001_4", 2'd1, 16'h8001, 4, 0);
        chk("sll_8001_4/const", 32'(model(2'd1, 16'h8001, 4)), 32'h0010);
        run_req("srl_8001_4", 2'd3, 16'h8001, 4, 0);
        run_req("srl_8000_15", 2'd3, 16'h8000, 15, 0);
        run_req("rol_8001_4", 2'd0, 16'h8001, 4, 0);
        run_req("ror_8001_4", 2'd2, 16'h8001, 4, 0);
        run_req("rol_abcd_0", 2'd0, 16'hABCD, 0, 0);
        run_req("ror_abcd_0", 2'd2, 16'hABCD, 0, 0);
        run_req("ror_1234_15", 2'd2, 16'h1234, 15, 0);
        run_req("hold5", 2'd0, 16'h00F1, 7, 5);

        // Flush in PASS2
        start_req("flush_p2", 2'd0, 16'hC3A5, 5);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_p2/res_valid", 32'(res_valid), 32'd0);
        chk("flush_p2/req_ready", 32'(req_ready), 32'd1);
        chk("flush_p2/sh_cnt", 32'(sh_cnt), 32'd0);
        repeat (2) @(negedge clk);
        chk("flush_p2/stays_idle", 32'(res_valid), 32'd0);
        run_req("after_flush", 2'd2, 16'hC3A5, 5, 1);

        // Flush beats a simultaneous accept
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_data  = 16'hFFFF;
        req_cnt   = 4'd3;
        flush     = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_vs_accept/req_ready", 32'(req_ready), 32'd1);
        chk("flush_vs_accept/sh_in", 32'(sh_in), 32'd0);
        @(negedge clk);
        chk("flush_vs_accept/no_result", 32'(res_valid), 32'd0);

        // Flush in DONE while consumer is ready: result dropped
        start_req("flush_done", 2'd1, 16'h0F0F, 2);
        @(negedge clk);
        chk("flush_done/valid_before", 32'(res_valid), 32'd1);
        flush     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        res_ready = 1'b0;
        chk("flush_done/res_valid", 32'(res_valid), 32'd0);
        chk("flush_done/req_ready", 32'(req_ready), 32'd1);

        // Reset in PASS1
        start_req("rst_p1", 2'd0, 16'h1357, 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_p1/res_valid", 32'(res_valid), 32'd0);
        chk("rst_p1/req_ready", 32'(req_ready), 32'd1);
        chk("rst_p1/res_data", 32'(res_data), 32'd0);
        chk("rst_p1/sh_in", 32'(sh_in), 32'd0);
        chk("rst_p1/sh_cnt", 32'(sh_cnt), 32'd0);
        run_req("after_rst", 2'd3, 16'h1357, 9, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            k  = int'($urandom_range(0, 15));
            run_req($sformatf("rand%0d", i), op, a, k, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
